simd_alu_seq: RTL and testbench

SIMD_ALU_SEQ -- requirements
Module: simd_alu_seq

---
 rtl/simd_alu_seq.sv | 125 ++++++++++++
 tb/tb_simd_alu_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_seq.sv
// simd_alu_seq: 8-lane SIMD ALU with single-cycle ops and a lane-serial MULLO
// that reuses one 32x32 multiplier over eight cycles.
module simd_alu_seq #(
    parameter int LANES = 8,
    parameter int LW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [LANES*LW-1:0]   s_vec,
    input  logic [LANES*LW-1:0]   t_vec,
    input  logic [31:0]           d_addr,
    input  logic                  kill,
    output logic                  wb_en,
    output logic [LANES*LW-1:0]   wb_data,
    output logic [31:0]           wb_addr,
    output logic                  busy
);
    typedef enum logic {IDLE, MUL} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [3:0]            op_q, op_d;
    logic [LANES*LW-1:0]   s_q, s_d, t_q, t_d, mul_q, mul_d, wb_data_q, wb_data_d, alu;
    logic [31:0]           addr_q, addr_d, wb_addr_q, wb_addr_d;
    logic                  wb_en_q, wb_en_d, accept;
    logic [LW-1:0]         prod;

    function automatic logic [LW-1:0] lane_op(input logic [3:0] o, input logic [LW-1:0] a, input logic [LW-1:0] b);
        case (o)
            4'd0:    lane_op = a + b;
            4'd1:    lane_op = a - b;
            4'd2:    lane_op = a & b;
            4'd3:    lane_op = a | b;
            4'd4:    lane_op = a ^ b;
            4'd5:    lane_op = {{(LW-1){1'b0}}, $signed(a) < $signed(b)};
            4'd7:    lane_op = $signed(a) > $signed(b) ? a : b;
            default: lane_op = a;
        endcase
    endfunction

    assign in_ready = (state_q == IDLE) && !kill;
    assign busy     = (state_q == MUL);
    assign accept   = in_valid && in_ready;
    assign wb_en    = wb_en_q;
    assign wb_data  = wb_data_q;
    assign wb_addr  = wb_addr_q;
    assign prod     = s_q[{cnt_q, 5'd0} +: LW] * t_q[{cnt_q, 5'd0} +: LW];

    always_comb begin
        alu = '0;
        for (int i = 0; i < LANES; i++)
            alu[i*LW +: LW] = lane_op(op, s_vec[i*LW +: LW], t_vec[i*LW +: LW]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        s_d       = s_q;
        t_d       = t_q;
        addr_d    = addr_q;
        mul_d     = mul_q;
        wb_en_d   = 1'b0;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        if (state_q == IDLE) begin
            if (accept) begin
                op_d   = op;
                s_d    = s_vec;
                t_d    = t_vec;
                addr_d = d_addr;
                if (op == 4'd6) begin
                    state_d = MUL;
                    cnt_d   = 3'd0;
                end else begin
                    wb_en_d   = 1'b1;
                    wb_data_d = alu;
                    wb_addr_d = d_addr;
                end
            end
        end else if (kill) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else begin
            // the last lane goes straight into wb_data alongside the earlier seven
            mul_d[{cnt_q, 5'd0} +: LW] = prod;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                state_d   = IDLE;
                wb_en_d   = 1'b1;
                wb_data_d = mul_d;
                wb_addr_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            s_q       <= '0;
            t_q       <= '0;
            addr_q    <= '0;
            mul_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            s_q       <= s_d;
            t_q       <= t_d;
            addr_q    <= addr_d;
            mul_q     <= mul_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
        end
    end
endmodule

// File: tb/tb_simd_alu_seq.sv
// tb_simd_alu_seq: directed and randomized checks of simd_alu_seq against a
// lane-wise integer reference model.
module tb_simd_alu_seq;
    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, kill = 1'b0;
    logic [3:0]   op = '0;
    logic [255:0] s_vec = '0, t_vec = '0;
    logic [31:0]  d_addr = '0;
    logic         in_ready, wb_en, busy;
    logic [255:0] wb_data, exp_v;
    logic [31:0]  wb_addr, exp_a;
    int           total = 0, bad = 0;

    simd_alu_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .s_vec(s_vec), .t_vec(t_vec), .d_addr(d_addr), .kill(kill), .wb_en(wb_en),
        .wb_data(wb_data), .wb_addr(wb_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] rv();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Each lane is treated as a signed 32-bit integer; int arithmetic wraps mod 2^32.
    function automatic logic [255:0] model(input logic [3:0] o, input logic [255:0] s, input logic [255:0] t);
        logic [255:0] r;
        int a, b, y;
        for (int i = 0; i < 8; i++) begin
            a = s[i*32 +: 32];
            b = t[i*32 +: 32];
            case (o)
                0: y = a + b;
                1: y = a - b;
                2: y = a & b;
                3: y = a | b;
                4: y = a ^ b;
                5: y = (a < b) ? 1 : 0;
                6: y = a * b;
                7: y = (a > b) ? a : b;
                default: y = a;
            endcase
            r[i*32 +: 32] = y;
        end
        return r;
    endfunction

    initial begin
        tick();
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            s_vec[i*32 +: 32] = 32'hFFFF_FFFF;
            t_vec[i*32 +: 32] = 32'h0000_0001;
        end
        op = 4'd0; d_addr = 32'h7654_3210; in_valid = 1'b1;
        tick();
        chk("add_wb_en", wb_en, 1);
        chk("add_wrap", wb_data, 0);
        chk("add_addr", wb_addr, 32'h7654_3210);
        in_valid = 1'b0; s_vec = rv(); d_addr = 32'h0;
        tick();
        chk("idle_wb_en", wb_en, 0);
        chk("hold_data", wb_data, 0);
        chk("hold_addr", wb_addr, 32'h7654_3210);

        for (int k = 0; k < 2; k++) begin
            s_vec = rv(); t_vec = rv();
            s_vec[31:0] = 32'h8000_0000; t_vec[31:0] = 32'h0000_0001;
            op = (k == 0) ? 4'd5 : 4'd7; d_addr = 32'h0; in_valid = 1'b1;
            tick();
            chk(k == 0 ? "slt_lane0" : "max_lane0", wb_data[31:0], k == 0 ? 32'h1 : 32'h1);
            chk(k == 0 ? "slt_vec" : "max_vec", wb_data, model(op, s_vec, t_vec));
            chk("d_addr_zero", wb_addr, 0);
        end

        for (int k = 0; k < 20; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd6) op = 4'd7;
            s_vec = rv(); t_vec = rv(); d_addr = $urandom;
            exp_v = model(op, s_vec, t_vec); exp_a = d_addr;
            tick();
            chk("b2b_wb_en", wb_en, 1);
            chk("b2b_data", wb_data, exp_v);
            chk("b2b_addr", wb_addr, exp_a);
        end

        chk("ready_in_wb_cycle", in_ready, 1);
        op = 4'd6; d_addr = 32'hA5A5_0F0F;
        for (int i = 0; i < 8; i++) begin
            s_vec[i*32 +: 32] = i + 2;
            t_vec[i*32 +: 32] = 32'h0001_0000;
            exp_v[i*32 +: 32] = (i + 2) << 16;
        end
        tick();
        for (int c = 0; c < 8; c++) begin
            chk("mul_busy", busy, 1);
            chk("mul_not_ready", in_ready, 0);
            chk("mul_no_wb", wb_en, 0);
            s_vec = rv(); t_vec = rv(); op = 4'($urandom_range(0, 15)); d_addr = $urandom;
            in_valid = (c < 7) ? 1'($urandom) : 1'b0;
            tick();
        end
        chk("mul_wb_en", wb_en, 1);
        chk("mul_data", wb_data, exp_v);
        chk("mul_addr", wb_addr, 32'hA5A5_0F0F);
        chk("mul_done_busy", busy, 0);
        tick();
        chk("mul_single_pulse", wb_en, 0);

        for (int k = 0; k < 3; k++) begin
            op = 4'd6; s_vec = rv(); t_vec = rv(); d_addr = $urandom; in_valid = 1'b1;
            exp_v = model(6, s_vec, t_vec); exp_a = d_addr;
            tick();
            in_valid = 1'b0;
            repeat (7) tick();
            chk("rmul_pre", wb_en, 0);
            tick();
            chk("rmul_wb_en", wb_en, 1);
            chk("rmul_data", wb_data, exp_v);
            chk("rmul_addr", wb_addr, exp_a);
        end

        exp_v = wb_data; exp_a = wb_addr;
        op = 4'd6; s_vec = rv(); t_vec = rv(); d_addr = 32'h1111_2222; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        kill = 1'b1; in_valid = 1'b1; op = 4'd0;
        #1;
        chk("kill_ready", in_ready, 0);
        tick();
        chk("kill_busy", busy, 0);
        chk("kill_no_wb", wb_en, 0);
        op = 4'd2;
        tick();
        chk("kill_idle_no_accept", wb_en, 0);
        kill = 1'b0; in_valid = 1'b0;
        repeat (8) tick();
        chk("kill_no_late_wb", wb_en, 0);
        chk("kill_hold_data", wb_data, exp_v);
        chk("kill_hold_addr", wb_addr, exp_a);

        op = 4'd4; s_vec = rv(); t_vec = rv(); d_addr = $urandom; in_valid = 1'b1;
        exp_v = model(op, s_vec, t_vec);
        tick();
        in_valid = 1'b0; kill = 1'b1;
        #1;
        chk("kill_keeps_wb", wb_en, 1);
        chk("kill_keeps_data", wb_data, exp_v);
        tick();
        kill = 1'b0;

        op = 4'd6; s_vec = rv(); t_vec = rv(); d_addr = 32'hDEAD_BEEF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("arst_wb_en", wb_en, 0);
        chk("arst_data", wb_data, 0);
        chk("arst_addr", wb_addr, 0);
        chk("arst_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_ready", in_ready, 1);
        for (int c = 0; c < 10; c++) begin
            chk("post_reset_no_wb", wb_en, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
